// File: rtl/boot_loader.sv
// Byte-stream program loader: frames length, little-endian words and an XOR checksum,
// writes words into instruction memory and releases the CPU once the image checks out.
module boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

  // Handshake: a byte moves on a rising edge where rx_valid & rx_ready is high and
  // reload is low; rx_ready is registered and only high in the intake states.
  state_t                state, state_d;
  logic [31:0]           len, len_d, len_shift;
  logic [1:0]            cnt, cnt_d;
  logic [ADDR_WIDTH:0]   word, word_d, word_inc;
  logic [23:0]           byte_buf, buf_d;
  logic [7:0]            csum, csum_d;
  logic                  rx_ready_d, we_d, take;
  logic [31:0]           addr_d, wdata_d;

  assign len_shift = {rx_data, len[31:8]};
  assign word_inc  = word + 1'b1;
  assign take      = rx_valid & rx_ready & ~reload;

  always_comb begin
    state_d = state;
    len_d   = len;
    cnt_d   = cnt;
    word_d  = word;
    buf_d   = byte_buf;
    csum_d  = csum;
    we_d    = 1'b0;
    addr_d  = imem_addr;
    wdata_d = imem_wdata;
    if (reload) begin
      state_d = S_LEN;
      len_d   = '0;
      cnt_d   = '0;
      word_d  = '0;
      buf_d   = '0;
      csum_d  = '0;
    end else if (take) begin
      case (state)
        S_LEN: begin
          len_d = len_shift;
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) begin
            word_d = '0;
            if (len_shift == 32'd0)                   state_d = S_CSUM;
            else if ({1'b0, len_shift} > MAX_WORDS)   state_d = S_ERR;
            else                                      state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum ^ rx_data;
          cnt_d  = cnt + 2'd1;
          case (cnt)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            default: begin
              // Completed word goes out on the following cycle while intake continues.
              we_d    = 1'b1;
              addr_d  = 32'({word[ADDR_WIDTH-1:0], 2'b00});
              wdata_d = {rx_data, byte_buf};
              word_d  = word_inc;
              if (word_inc == len[ADDR_WIDTH:0]) state_d = S_CSUM;
            end
          endcase
        end
        S_CSUM:  state_d = (rx_data == csum) ? S_DONE : S_ERR;
        default: state_d = state;
      endcase
    end
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_LEN;
      len        <= '0;
      cnt        <= '0;
      word       <= '0;
      byte_buf   <= '0;
      csum       <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state      <= state_d;
      len        <= len_d;
      cnt        <= cnt_d;
      word       <= word_d;
      byte_buf   <= buf_d;
      csum       <= csum_d;
      rx_ready   <= rx_ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
    end
  end

  assign cpu_run   = (state == S_DONE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign dbg_state = state;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: expected memory writes are queued as bytes are
// driven and matched by a write monitor; status outputs are checked per scenario.
module tb_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  run_csum;
  logic        we_prev = 1'b0;

  boot_loader #(.ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Write monitor / scoreboard
  always @(negedge clock) begin
    if (imem_we) begin
      logic [63:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e)
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        else n_pass++;
      end
      n_checks++;
      if (we_prev) $display("FAIL we_width: imem_we high on consecutive cycles, required 1 cycle");
      else n_pass++;
    end
    we_prev <= imem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    // Only a formatter: every call site supplies its own scenario-specific values.
    n_checks++;
    if (act !== req) $display("FAIL %s: got %h, required %h", name, act, req);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!rx_ready) begin
      n_checks++;
      $display("FAIL rx_ready_timeout: rx_ready=0 after %0d cycles, required 1", t);
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
  endtask

  task automatic send_len(input logic [31:0] n, input bit gaps);
    run_csum = 8'h00;
    for (int k = 0; k < 4; k++) begin
      send_byte(n[8*k +: 8]);
      gap(gaps);
    end
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back({32'(idx * 4), w});
      run_csum = run_csum ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
      gap(gaps);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    check("reload_done", done, 0);
    check("reload_error", error, 0);
    check("reload_cpu_run", cpu_run, 0);
  endtask

  task automatic test_reset();
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_ready_after", rx_ready, 1);
  endtask

  task automatic test_single();
    send_len(32'd1, 0);
    send_word(0, 32'h0050_0513, 0);
    check("single_cpu_run_pre", cpu_run, 0);
    send_byte(8'h46);
    check("single_done", done, 1);
    check("single_cpu_run", cpu_run, 1);
    check("single_error", error, 0);
    check("single_rx_ready", rx_ready, 0);
    drain("single_drain");
  endtask

  task automatic test_back_to_back();
    logic [31:0] img[3];
    pulse_reload();
    foreach (img[i]) img[i] = $urandom;
    send_len(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(i, img[i], 0);
    send_byte(run_csum);
    check("b2b_done", done, 1);
    drain("b2b_drain");
  endtask

  task automatic test_bad_csum();
    pulse_reload();
    send_len(32'd1, 0);
    send_word(0, 32'h0050_0513, 0);
    send_byte(run_csum ^ 8'h01);
    check("badcs_error", error, 1);
    check("badcs_cpu_run", cpu_run, 0);
    check("badcs_rx_ready", rx_ready, 0);
    check("badcs_done", done, 0);
    drain("badcs_drain");
  endtask

  task automatic test_zero_len();
    pulse_reload();
    send_len(32'd0, 0);
    send_byte(8'h00);
    check("zero_done", done, 1);
    check("zero_error", error, 0);
    drain("zero_drain");
  endtask

  task automatic test_overflow();
    pulse_reload();
    send_len(32'd1025, 0);
    check("ovf_error", error, 1);
    check("ovf_rx_ready", rx_ready, 0);
    check("ovf_cpu_run", cpu_run, 0);
    drain("ovf_drain");
  endtask

  task automatic test_gaps();
    logic [31:0] img[4];
    pulse_reload();
    foreach (img[i]) img[i] = $urandom;
    send_len(32'd4, 1);
    for (int i = 0; i < 4; i++) send_word(i, img[i], 1);
    send_byte(run_csum);
    check("gaps_done", done, 1);
    drain("gaps_drain");
  endtask

  task automatic test_reset_mid();
    pulse_reload();
    send_len(32'd3, 0);
    send_word(0, 32'hAAAA_0001, 0);
    send_word(1, 32'hBBBB_0002, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b0;
    #1;
    check("mid_rst_rx_ready", rx_ready, 0);
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b1;
    drain("mid_rst_drain");
    send_len(32'd2, 0);
    send_word(0, 32'h1234_5678, 0);
    send_word(1, 32'h9ABC_DEF0, 0);
    send_byte(run_csum);
    check("mid_done", done, 1);
    drain("mid_drain");
    pulse_reload();
    check("reload_rx_ready", rx_ready, 1);
    send_len(32'd2, 1);
    send_word(0, 32'hCAFE_F00D, 1);
    send_word(1, 32'h0BAD_BEEF, 1);
    check("reload_cpu_run_pre", cpu_run, 0);
    send_byte(run_csum);
    check("reload_cpu_run_post", cpu_run, 1);
    check("reload_done_post", done, 1);
    drain("reload_drain");
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_csum();
    test_zero_len();
    test_overflow();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
